// File: rtl/acc_pkg.sv
// Shared types and default sizes for the accumulator-bank sequencer.
// The state enum is used by the sequencer top.
package acc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    ACCUM,
    DRAIN
  } acc_seq_state_t;

  localparam int NUM_ACC_DEF = 8;
  localparam int IDX_W_DEF   = 3;
  localparam int K_W_DEF     = 8;

endpackage

// File: rtl/acc_seq_cnt.sv
// Up-counter with clear, enable and a terminal-count compare.
// On an enabled cycle at the terminal value it returns to zero instead of wrapping.
module acc_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  assign at_term = (cnt == term);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_term ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/acc_seq.sv
// Accumulator-bank sequencer: clear, optional bias load, k gated accumulate
// steps, then a valid/ready drain of every accumulator in the bank.
module acc_seq
  import acc_pkg::*;
#(
  parameter int NUM_ACC = NUM_ACC_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int K_W     = K_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [K_W-1:0]   cfg_k,
  input  logic             cfg_bias_en,
  output logic             busy,
  output logic             done,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic             acc_clr,
  output logic             load_vld,
  output logic             acc_vld,
  output logic [IDX_W-1:0] drain_sel,
  output logic             out_vld,
  input  logic             out_rdy
);

  acc_seq_state_t state_q, state_d;
  logic [K_W-1:0]   k_q;
  logic             bias_q;
  logic [K_W-1:0]   step_cnt;
  logic             step_last;
  logic [IDX_W-1:0] drain_idx;
  logic             drain_last;
  logic             cnt_clr;
  logic             drain_hs;
  logic             unused_step;

  assign cnt_clr     = (state_q == IDLE);
  assign drain_hs    = out_vld & out_rdy;
  assign unused_step = ^step_cnt;

  acc_seq_cnt #(.W(K_W)) u_step_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (acc_vld),
    .term    (k_q - K_W'(1)),
    .cnt     (step_cnt),
    .at_term (step_last)
  );

  acc_seq_cnt #(.W(IDX_W)) u_drain_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (drain_hs),
    .term    (IDX_W'(NUM_ACC - 1)),
    .cnt     (drain_idx),
    .at_term (drain_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      bias_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        k_q    <= cfg_k;
        bias_q <= cfg_bias_en;
      end
    end
  end

  // done follows the final drain handshake combinationally so it lands on
  // the same cycle the last word is taken.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    acc_clr   = 1'b0;
    load_vld  = 1'b0;
    in_rdy    = 1'b0;
    acc_vld   = 1'b0;
    out_vld   = 1'b0;
    done      = 1'b0;
    drain_sel = '0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = CLR;
      end
      CLR: begin
        busy    = 1'b1;
        acc_clr = 1'b1;
        if (bias_q)          state_d = LOAD;
        else if (k_q != '0)  state_d = ACCUM;
        else                 state_d = DRAIN;
      end
      LOAD: begin
        busy     = 1'b1;
        load_vld = 1'b1;
        state_d  = (k_q != '0) ? ACCUM : DRAIN;
      end
      ACCUM: begin
        busy    = 1'b1;
        in_rdy  = 1'b1;
        acc_vld = in_vld;
        if (in_vld && step_last) state_d = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_vld   = 1'b1;
        drain_sel = drain_idx;
        done      = out_rdy & drain_last;
        if (out_rdy && drain_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_acc_seq.sv
// Self-checking bench for acc_seq: per-cycle expected output words are built
// from a timeline of each tile, queued as stimulus is driven, and compared.
module tb_acc_seq;
  import acc_pkg::*;

  localparam int NUM_ACC = 8;
  localparam int IDX_W   = 3;
  localparam int K_W     = 8;
  localparam int VW      = 7 + IDX_W;
  localparam int MAXC    = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [K_W-1:0]   cfg_k;
  logic             cfg_bias_en;
  logic             busy;
  logic             done;
  logic             in_vld;
  logic             in_rdy;
  logic             acc_clr;
  logic             load_vld;
  logic             acc_vld;
  logic [IDX_W-1:0] drain_sel;
  logic             out_vld;
  logic             out_rdy;

  int errors = 0;
  int checks = 0;

  bit start_pat  [MAXC];
  bit in_vld_pat [MAXC];
  bit out_rdy_pat[MAXC];
  bit rst_pat    [MAXC];
  logic [VW-1:0] exp_vec[MAXC];
  logic [VW-1:0] exp_q[$];

  acc_seq #(.NUM_ACC(NUM_ACC), .IDX_W(IDX_W), .K_W(K_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_k       (cfg_k),
    .cfg_bias_en (cfg_bias_en),
    .busy        (busy),
    .done        (done),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .acc_clr     (acc_clr),
    .load_vld    (load_vld),
    .acc_vld     (acc_vld),
    .drain_sel   (drain_sel),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk(bit b, bit r, bit c, bit l, bit a, bit o, bit d, int sel);
    logic [IDX_W-1:0] s;
    s = IDX_W'(sel);
    return {b, r, c, l, a, o, d, s};
  endfunction

  function automatic logic [VW-1:0] observed();
    return {busy, in_rdy, acc_clr, load_vld, acc_vld, out_vld, done, drain_sel};
  endfunction

  task automatic clearPatterns();
    for (int c = 0; c < MAXC; c++) begin
      start_pat[c]   = 1'b0;
      in_vld_pat[c]  = 1'b1;
      out_rdy_pat[c] = 1'b1;
      rst_pat[c]     = 1'b0;
      exp_vec[c]     = '0;
    end
  endtask

  // Walk one tile's timeline from its start cycle; a reset cuts it short.
  task automatic addTile(input int s, input int k, input bit bias, input int rst_at);
    int c, lim, steps, idx;
    bit hs;
    lim = (rst_at < 0) ? MAXC - 1 : rst_at;
    start_pat[s] = 1'b1;
    c = s + 1;
    if (c > lim) return;
    exp_vec[c] = mk(1, 0, 1, 0, 0, 0, 0, 0);
    c++;
    if (bias) begin
      if (c > lim) return;
      exp_vec[c] = mk(1, 0, 0, 1, 0, 0, 0, 0);
      c++;
    end
    steps = 0;
    while (steps < k) begin
      if (c > lim) return;
      exp_vec[c] = mk(1, 1, 0, 0, in_vld_pat[c], 0, 0, 0);
      if (in_vld_pat[c]) steps++;
      c++;
    end
    idx = 0;
    while (idx < NUM_ACC) begin
      if (c > lim) return;
      hs = out_rdy_pat[c];
      exp_vec[c] = mk(1, 0, 0, 0, 0, 1, hs && (idx == NUM_ACC - 1), idx);
      if (hs) idx++;
      c++;
    end
  endtask

  task automatic applyReset(input int scen);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput($sformatf("s%0d rst", scen), observed(), '0);
  endtask

  task automatic applyStimulus(input int scen, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      rst     = rst_pat[c];
      start   = start_pat[c];
      in_vld  = in_vld_pat[c];
      out_rdy = out_rdy_pat[c];
      exp_q.push_back(exp_vec[c]);
      @(negedge clk);
      checkOutput($sformatf("s%0d c%0d", scen, c), observed(), exp_q.pop_front());
      checkOutput($sformatf("s%0d c%0d excl", scen, c),
                  32'($countones({acc_clr, load_vld, acc_vld}) <= 1), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    cfg_k = '0; cfg_bias_en = 1'b0;

    // Basic tile: k=3, no bias, everything streaming.
    clearPatterns();
    cfg_k = 8'd3; cfg_bias_en = 1'b0;
    addTile(1, 3, 0, -1);
    applyReset(1);
    applyStimulus(1, 16);

    // Bias preload before two steps.
    clearPatterns();
    cfg_k = 8'd2; cfg_bias_en = 1'b1;
    addTile(1, 2, 1, -1);
    applyReset(2);
    applyStimulus(2, 16);

    // Gappy operand stream during ACCUM.
    clearPatterns();
    cfg_k = 8'd4; cfg_bias_en = 1'b0;
    in_vld_pat[3] = 1; in_vld_pat[4] = 0; in_vld_pat[5] = 0; in_vld_pat[6] = 1;
    in_vld_pat[7] = 1; in_vld_pat[8] = 0; in_vld_pat[9] = 1;
    addTile(1, 4, 0, -1);
    applyReset(3);
    applyStimulus(3, 20);

    // Downstream stall at drain index 2.
    clearPatterns();
    cfg_k = 8'd1; cfg_bias_en = 1'b0;
    out_rdy_pat[6] = 0; out_rdy_pat[7] = 0; out_rdy_pat[8] = 0;
    addTile(1, 1, 0, -1);
    applyReset(4);
    applyStimulus(4, 17);

    // k=0 skips ACCUM; starts during DRAIN and on the done cycle are ignored.
    clearPatterns();
    cfg_k = 8'd0; cfg_bias_en = 1'b0;
    addTile(1, 0, 0, -1);
    start_pat[5]  = 1'b1;
    start_pat[10] = 1'b1;
    applyReset(5);
    applyStimulus(5, 13);

    // Reset after one of five steps, then a fresh five-step tile.
    clearPatterns();
    cfg_k = 8'd5; cfg_bias_en = 1'b0;
    in_vld_pat[4] = 1'b0;
    rst_pat[4]    = 1'b1;
    addTile(1, 5, 0, 4);
    addTile(7, 5, 0, -1);
    applyReset(6);
    applyStimulus(6, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
